// File: rtl/background_drawer_if.sv
// background_drawer_if: control handshake plus ROM and VGA pixel bus of the background drawer.
interface background_drawer_if #(
   parameter int ADDR_W  = 17,
   parameter int COLOR_W = 9,
   parameter int X_W     = 9,
   parameter int Y_W     = 8
);
   logic               start;
   logic [ADDR_W-1:0]  rom_address;
   logic [COLOR_W-1:0] rom_q;
   logic [X_W-1:0]     x;
   logic [Y_W-1:0]     y;
   logic [COLOR_W-1:0] colour;
   logic               plot;
   logic               busy;
   logic               done;
   modport master (input start, rom_q, output rom_address, x, y, colour, plot, busy, done);
   modport slave (output start, rom_q, input rom_address, x, y, colour, plot, busy, done);
endinterface

// File: rtl/background_drawer.sv
// background_drawer: streams the background ROM into the VGA framebuffer, one pixel per clock,
// through a two-stage pipeline matching the ROM's registered-address read.
module background_drawer #(
   parameter int WIDTH   = 320,
   parameter int HEIGHT  = 240,
   parameter int ADDR_W  = 17,
   parameter int COLOR_W = 9,
   parameter int X_W     = 9,
   parameter int Y_W     = 8
) (
   input logic clock,
   input logic reset,
   background_drawer_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam longint PIXELS = longint'(WIDTH) * longint'(HEIGHT);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);
   localparam logic [X_W-1:0] COL_LAST = X_W'(WIDTH - 1);
   if (WIDTH < 1 || HEIGHT < 1 || PIXELS > (longint'(1) << ADDR_W) ||
       longint'(WIDTH) > (longint'(1) << X_W) || longint'(HEIGHT) > (longint'(1) << Y_W)) begin : g_param_check
      $error("background_drawer: frame geometry does not fit ADDR_W/X_W/Y_W");
   end
   logic [1:0]         state;
   logic [ADDR_W-1:0]  addr;
   logic [X_W-1:0]     col, s1_col, x_r;
   logic [Y_W-1:0]     row, s1_row, y_r;
   logic               s1_valid, drain_cnt, plot_r;
   logic [COLOR_W-1:0] colour_r;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         col       <= '0;
         row       <= '0;
         drain_cnt <= 1'b0;
         s1_valid  <= 1'b0;
         s1_col    <= '0;
         s1_row    <= '0;
         x_r       <= '0;
         y_r       <= '0;
         colour_r  <= '0;
         plot_r    <= 1'b0;
      end else begin
         s1_valid <= state == FETCH;
         s1_col   <= col;
         s1_row   <= row;
         plot_r   <= s1_valid;
         // x/y/colour only move on a real pixel so they hold while plot is low
         if (s1_valid) begin
            x_r      <= s1_col;
            y_r      <= s1_row;
            colour_r <= bus.rom_q;
         end
         case (state)
            IDLE: if (bus.start) begin
               state <= FETCH;
               addr  <= '0;
               col   <= '0;
               row   <= '0;
            end
            FETCH: if (addr == LAST) begin
               state     <= DRAIN;
               drain_cnt <= 1'b0;
            end else begin
               addr <= addr + 1'b1;
               col  <= col == COL_LAST ? '0 : col + 1'b1;
               row  <= col == COL_LAST ? row + 1'b1 : row;
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) state <= DONE;
            end
            default: begin
               state <= IDLE;
               addr  <= '0;
            end
         endcase
      end
   end
   assign bus.rom_address = addr;
   assign bus.x           = x_r;
   assign bus.y           = y_r;
   assign bus.colour      = colour_r;
   assign bus.plot        = plot_r;
   assign bus.busy        = state != IDLE;
   assign bus.done        = state == DONE;
endmodule

// File: tb/tb_background_drawer.sv
// tb_background_drawer: random start/reset stimulus on a 4x3 frame plus one full 320x240 frame,
// each checked cycle by cycle against a timing model keyed to the start-sampling cycle.
module tb_background_drawer;
   localparam int NW = 4, NH = 3, NS = NW * NH;
   localparam int WL = 320, NL = 320 * 240;
   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0, n_fail = 0;
   background_drawer_if bs ();
   background_drawer_if bl ();
   background_drawer #(.WIDTH(NW), .HEIGHT(NH)) dut_s (.clock(clock), .reset(reset), .bus(bs.master));
   background_drawer dut_l (.clock(clock), .reset(reset), .bus(bl.master));
   always #5 clock = ~clock;
   always @(posedge clock) begin
      bs.rom_q <= 9'(bs.rom_address + 17'd5);
      bl.rom_q <= bl.rom_address[8:0];
      cyc      <= cyc + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   // model: a frame is fully determined by the cycle s in which start was sampled while idle
   logic act_s, act_l;
   int   s_s, s_l, pc_s, pc_l, p_s, p_l;
   assign p_s = act_s ? cyc - s_s : -1;
   assign p_l = act_l ? cyc - s_l : -1;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         act_s <= 1'b0;
         act_l <= 1'b0;
      end else begin
         if (act_s && cyc - s_s == NS + 3) act_s <= 1'b0;
         else if (!act_s && bs.start) begin act_s <= 1'b1; s_s <= cyc; end
         if (act_l && cyc - s_l == NL + 3) act_l <= 1'b0;
         else if (!act_l && bl.start) begin act_l <= 1'b1; s_l <= cyc; end
      end
   end
   always @(negedge clock) begin
      check("s_busy", 32'(bs.busy), 32'(act_s));
      check("s_plot", 32'(bs.plot), 32'(act_s && p_s >= 3 && p_s <= NS + 2));
      check("s_done", 32'(bs.done), 32'(act_s && p_s == NS + 3));
      if (!act_s || p_s <= NS + 2)
         check("s_addr", 32'(bs.rom_address), !act_s ? 0 : (p_s <= NS ? p_s - 1 : NS - 1));
      if (act_s && bs.plot && p_s >= 3) begin
         check("s_x", 32'(bs.x), (p_s - 3) % NW);
         check("s_y", 32'(bs.y), (p_s - 3) / NW);
         check("s_colour", 32'(bs.colour), (p_s - 3 + 5) % 512);
      end
      if (act_s && p_s == NS + 3) check("s_count", pc_s, NS);
      if (act_s && p_s == 1) pc_s <= 0;
      else if (bs.plot) pc_s <= pc_s + 1;
   end
   always @(negedge clock) begin
      check("l_busy", 32'(bl.busy), 32'(act_l));
      check("l_plot", 32'(bl.plot), 32'(act_l && p_l >= 3 && p_l <= NL + 2));
      check("l_done", 32'(bl.done), 32'(act_l && p_l == NL + 3));
      if (!act_l || p_l <= NL + 2)
         check("l_addr", 32'(bl.rom_address), !act_l ? 0 : (p_l <= NL ? p_l - 1 : NL - 1));
      if (act_l && bl.plot && p_l >= 3) begin
         check("l_x", 32'(bl.x), (p_l - 3) % WL);
         check("l_y", 32'(bl.y), (p_l - 3) / WL);
         check("l_colour", 32'(bl.colour), (p_l - 3) % 512);
      end
      if (act_l && p_l == NL + 3) check("l_count", pc_l, NL);
      if (act_l && p_l == 1) pc_l <= 0;
      else if (bl.plot) pc_l <= pc_l + 1;
   end
   task automatic check_zero(input string tag);
      check({tag, "_plot"}, 32'(bs.plot), 0);
      check({tag, "_busy"}, 32'(bs.busy), 0);
      check({tag, "_done"}, 32'(bs.done), 0);
      check({tag, "_addr"}, 32'(bs.rom_address), 0);
      check({tag, "_x"}, 32'(bs.x), 0);
      check({tag, "_y"}, 32'(bs.y), 0);
      check({tag, "_colour"}, 32'(bs.colour), 0);
   endtask
   task automatic pulse_s;
      bs.start = 1'b1;
      @(negedge clock);
      bs.start = 1'b0;
   endtask
   initial begin
      reset    = 1'b1;
      bs.start = 1'b0;
      bl.start = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("rst");
      #2 reset = 1'b0;
      repeat (100) @(negedge clock);
      check_zero("idle");
      pulse_s();
      repeat (20) @(negedge clock);
      pulse_s();
      repeat (5) @(negedge clock);
      pulse_s();
      repeat (15) @(negedge clock);
      pulse_s();
      repeat (7) @(negedge clock);
      #2 reset = 1'b1;
      #1 check_zero("midrst");
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      pulse_s();
      repeat (20) @(negedge clock);
      bs.start = 1'b1;
      repeat (50) @(negedge clock);
      bs.start = 1'b0;
      repeat (20) @(negedge clock);
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge clock);
         bs.start = 1'b1;
         repeat ($urandom_range(1, 20)) @(negedge clock);
         bs.start = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 14)) @(negedge clock);
            #2 reset = 1'b1;
            @(negedge clock);
            #2 reset = 1'b0;
         end
      end
      repeat (20) @(negedge clock);
      bl.start = 1'b1;
      @(negedge clock);
      bl.start = 1'b0;
      repeat (NL + 10) @(negedge clock);
      check("l_hold_x", 32'(bl.x), 319);
      check("l_hold_y", 32'(bl.y), 239);
      check("l_hold_colour", 32'(bl.colour), 511);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
